cdc_fifo_ingress_arb: RTL and testbench



---
 rtl/cdc_fifo_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/cdc_fifo_ingress_arb.sv | 158 +++++++++++++++
 tb/tb_cdc_fifo_ingress_arb.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_fifo_pkg.sv
// Shared types and default sizes for the CDC FIFO and its ingress arbiter.
package cdc_fifo_pkg;

  localparam int unsigned FIFO_WIDTH = 8;
  localparam int unsigned FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    StIdle,
    StXfer,
    StGap
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from ptr, with wrap.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PtrW-1:0] ptr,
  output logic [NREQ-1:0] gnt
);

  logic            found;
  logic [PtrW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      idx = PtrW'((int'(ptr) + k) % int'(NREQ));
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdc_fifo_ingress_arb.sv
// Round-robin burst arbiter feeding the CDC FIFO write side, with a fixed idle gap between
// bursts so the egress side can observe each valid_a drop.
module cdc_fifo_ingress_arb
  import cdc_fifo_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned WIDTH     = FIFO_WIDTH,
  parameter int unsigned MAX_BURST = FIFO_DEPTH,
  parameter int unsigned GAP       = 8
) (
  input  logic                  clk_a,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  output logic                  valid_a,
  output logic [WIDTH-1:0]      data_a,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic                  done,
  output logic                  truncated,
  output logic                  underrun
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntW = $clog2(MAX_BURST) + 1;
  localparam int unsigned GapW = $clog2(GAP) + 1;

  arb_state_t       state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [PtrW-1:0]  rr_q, rr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [GapW-1:0]  gcnt_q, gcnt_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;
  logic             trunc_q, trunc_d;
  logic             under_q, under_d;

  logic [NREQ-1:0]  arb_gnt;
  logic [PtrW-1:0]  g_idx;
  logic             g_valid;
  logic             g_last;
  logic [WIDTH-1:0] g_data;
  logic             burst_end;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_rr_arbiter (
    .req(req_valid),
    .ptr(rr_q),
    .gnt(arb_gnt)
  );

  // Owner index from the registered one-hot grant.
  always_comb begin
    g_idx = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (grant_q[k]) g_idx = PtrW'(k);
    end
  end

  assign g_valid = req_valid[g_idx];
  assign g_last  = req_last[g_idx];
  assign g_data  = req_data[int'(g_idx)*int'(WIDTH) +: WIDTH];

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    gcnt_d    = gcnt_q;
    valid_d   = 1'b0;
    data_d    = data_q;
    done_d    = 1'b0;
    trunc_d   = 1'b0;
    under_d   = 1'b0;
    burst_end = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|req_valid) begin
          grant_d = arb_gnt;
          cnt_d   = '0;
          state_d = StXfer;
        end
      end
      StXfer: begin
        if (g_valid) begin
          valid_d = 1'b1;
          data_d  = g_data;
          cnt_d   = cnt_q + 1'b1;
          if (g_last) begin
            done_d    = 1'b1;
            burst_end = 1'b1;
          end else if (cnt_q == CntW'(MAX_BURST - 1)) begin
            trunc_d   = 1'b1;
            burst_end = 1'b1;
          end
        end else begin
          under_d   = 1'b1;
          burst_end = 1'b1;
        end
        if (burst_end) begin
          rr_d    = (g_idx == PtrW'(NREQ - 1)) ? '0 : g_idx + 1'b1;
          grant_d = '0;
          gcnt_d  = '0;
          state_d = StGap;
        end
      end
      StGap: begin
        if (gcnt_q == GapW'(GAP - 1)) begin
          state_d = StIdle;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_a) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      trunc_q <= 1'b0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      done_q  <= done_d;
      trunc_q <= trunc_d;
      under_q <= under_d;
    end
  end

  assign req_ready = (state_q == StXfer) ? grant_q : '0;
  assign valid_a   = valid_q;
  assign data_a    = data_q;
  assign grant     = grant_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign truncated = trunc_q;
  assign underrun  = under_q;

endmodule

// File: tb/tb_cdc_fifo_ingress_arb.sv
// Bench for cdc_fifo_ingress_arb: directed scenarios plus random traffic, checked each cycle
// against a behavioural owner/gap model.
module tb_cdc_fifo_ingress_arb;

  localparam int NREQ      = 4;
  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 16;
  localparam int GAP       = 8;

  logic                  clk_a = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic                  valid_a;
  logic [WIDTH-1:0]      data_a;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic                  done;
  logic                  truncated;
  logic                  underrun;

  cdc_fifo_ingress_arb #(
    .NREQ(NREQ),
    .WIDTH(WIDTH),
    .MAX_BURST(MAX_BURST),
    .GAP(GAP)
  ) dut (
    .clk_a(clk_a),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .valid_a(valid_a),
    .data_a(data_a),
    .grant(grant),
    .busy(busy),
    .done(done),
    .truncated(truncated),
    .underrun(underrun)
  );

  always #5 clk_a = ~clk_a;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  // Requester behaviour
  int act[NREQ], len[NREQ], pos[NREQ], pkts[NREQ], drop_at[NREQ];
  bit rnd_mode = 0;

  // Behavioural model: current owner (-1 none), gap cycles still to serve, words this burst
  int              m_owner, m_gap, m_words, m_rr;
  bit              m_valid, m_done, m_trunc, m_under;
  logic [WIDTH-1:0] m_data;
  logic [NREQ-1:0] m_accept;

  // Monitor
  int q_bursts[$], q_owners[$], q_rise_gaps[$];
  int run_len, last_word_cyc, first_rise, n_done, n_trunc, n_under;
  logic prev_valid;
  logic [NREQ-1:0] prev_grant;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic clear_mon();
    q_bursts.delete();
    q_owners.delete();
    q_rise_gaps.delete();
    run_len = 0; last_word_cyc = -1; first_rise = -1;
    n_done = 0; n_trunc = 0; n_under = 0;
    prev_valid = 1'b0; prev_grant = '0;
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = (act[i] != 0) && !(rnd_mode && ($urandom_range(0, 99) < 3));
      req_data[i*WIDTH +: WIDTH] = 8'((i * 37 + pos[i] * 5 + len[i]) & 255);
      req_last[i] = (act[i] != 0) && (pos[i] == len[i] - 1);
    end
  endtask

  task automatic model_step();
    int o;
    m_accept = '0;
    m_valid  = 0; m_done = 0; m_trunc = 0; m_under = 0;
    if (rst) begin
      m_owner = -1; m_gap = 0; m_words = 0; m_rr = 0; m_data = '0;
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (m_owner < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        if (m_owner < 0 && req_valid[(m_rr + k) % NREQ]) begin
          m_owner = (m_rr + k) % NREQ;
          m_words = 0;
        end
      end
    end else begin
      o = m_owner;
      if (req_valid[o]) begin
        m_accept[o] = 1'b1;
        m_valid = 1;
        m_data  = req_data[o*WIDTH +: WIDTH];
        m_words++;
        if (req_last[o]) m_done = 1;
        else if (m_words == MAX_BURST) m_trunc = 1;
      end else begin
        m_under = 1;
      end
      if (m_done || m_trunc || m_under) begin
        m_rr = (o + 1) % NREQ;
        m_owner = -1;
        m_gap = GAP;
      end
    end
  endtask

  task automatic check();
    logic [NREQ-1:0] e_grant;
    e_grant = (m_owner >= 0) ? NREQ'(1 << m_owner) : '0;
    chk("valid_a", 32'(valid_a), 32'(m_valid));
    chk("data_a", 32'(data_a), 32'(m_data));
    chk("grant", 32'(grant), 32'(e_grant));
    chk("req_ready", 32'(req_ready), 32'(e_grant));
    chk("busy", 32'(busy), 32'((m_owner >= 0) || (m_gap > 0)));
    chk("done", 32'(done), 32'(m_done));
    chk("truncated", 32'(truncated), 32'(m_trunc));
    chk("underrun", 32'(underrun), 32'(m_under));
    if (valid_a === 1'b1 && !prev_valid) begin
      if (first_rise < 0) first_rise = cyc;
      if (last_word_cyc >= 0) q_rise_gaps.push_back(cyc - last_word_cyc);
    end
    if (valid_a === 1'b1) begin
      run_len++;
      last_word_cyc = cyc;
    end else if (prev_valid) begin
      q_bursts.push_back(run_len);
      run_len = 0;
    end
    if (grant != 0 && prev_grant == 0)
      for (int k = 0; k < NREQ; k++) if (grant[k]) q_owners.push_back(k);
    if (done === 1'b1) n_done++;
    if (truncated === 1'b1) n_trunc++;
    if (underrun === 1'b1) n_under++;
    prev_valid = (valid_a === 1'b1);
    prev_grant = grant;
  endtask

  task automatic advance();
    for (int i = 0; i < NREQ; i++) begin
      if (m_accept[i]) begin
        pos[i]++;
        if (pos[i] == len[i]) begin
          if (pkts[i] > 0) begin pkts[i]--; pos[i] = 0; end
          else act[i] = 0;
        end else if (pos[i] == drop_at[i]) begin
          act[i] = 0;
        end
      end
    end
  endtask

  task automatic tick();
    drive();
    model_step();
    @(posedge clk_a);
    @(negedge clk_a);
    cyc++;
    check();
    advance();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic idle_reqs();
    for (int i = 0; i < NREQ; i++) begin
      act[i] = 0; len[i] = 1; pos[i] = 0; pkts[i] = 0; drop_at[i] = -1;
    end
  endtask

  task automatic start(input int i, input int l, input int np, input int drop);
    act[i] = 1; len[i] = l; pos[i] = 0; pkts[i] = np; drop_at[i] = drop;
  endtask

  task automatic do_reset();
    idle_reqs();
    rst = 1'b1;
    ticks(3);
    rst = 1'b0;
    clear_mon();
  endtask

  initial begin
    int t0;
    bit found;
    req_valid = '0; req_data = '0; req_last = '0; rst = 1'b1;
    m_owner = -1; m_gap = 0; m_words = 0; m_rr = 0; m_data = '0;
    idle_reqs();
    clear_mon();
    @(negedge clk_a);

    // Reset state
    do_reset();
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Single 5-word packet from req0
    t0 = cyc;
    start(0, 5, 0, -1);
    ticks(25);
    chk("t1_latency", 32'(first_rise - t0), 32'd2);
    chk("t1_nbursts", 32'(q_bursts.size()), 32'd1);
    if (q_bursts.size() == 1) chk("t1_len", 32'(q_bursts[0]), 32'd5);
    chk("t1_done", 32'(n_done), 32'd1);

    // req0 (two packets) and req2 (one) compete
    do_reset();
    start(0, 3, 1, -1);
    start(2, 3, 0, -1);
    ticks(60);
    chk("t2_nown", 32'(q_owners.size()), 32'd3);
    if (q_owners.size() == 3) begin
      chk("t2_own0", 32'(q_owners[0]), 32'd0);
      chk("t2_own1", 32'(q_owners[1]), 32'd2);
      chk("t2_own2", 32'(q_owners[2]), 32'd0);
    end
    chk("t2_ngaps", 32'(q_rise_gaps.size()), 32'd2);
    foreach (q_rise_gaps[k]) chk("t2_spacing", 32'(q_rise_gaps[k]), 32'(GAP + 2));

    // 20-word packet from req1: split 16 + 4
    do_reset();
    start(1, 20, 0, -1);
    ticks(60);
    chk("t3_nbursts", 32'(q_bursts.size()), 32'd2);
    if (q_bursts.size() == 2) begin
      chk("t3_len0", 32'(q_bursts[0]), 32'd16);
      chk("t3_len1", 32'(q_bursts[1]), 32'd4);
    end
    chk("t3_trunc", 32'(n_trunc), 32'd1);
    chk("t3_done", 32'(n_done), 32'd1);

    // req3 drops after 3 words; pointer wraps to 0
    do_reset();
    start(3, 10, 0, 3);
    ticks(20);
    start(0, 1, 0, -1);
    start(1, 1, 0, -1);
    ticks(40);
    chk("t4_under", 32'(n_under), 32'd1);
    if (q_bursts.size() > 0) chk("t4_len", 32'(q_bursts[0]), 32'd3);
    chk("t4_nown", 32'(q_owners.size()), 32'd3);
    if (q_owners.size() == 3) begin
      chk("t4_own1", 32'(q_owners[1]), 32'd0);
      chk("t4_own2", 32'(q_owners[2]), 32'd1);
    end

    // Reset on the 4th word of a 10-word burst
    do_reset();
    start(1, 1, 0, -1);
    ticks(15);
    start(0, 10, 0, -1);
    found = 0;
    for (int n = 0; n < 60; n++) begin
      if (!found) begin
        if (pos[0] == 3 && m_owner == 0) found = 1;
        else tick();
      end
    end
    chk("t5_reach", 32'(found), 32'd1);
    rst = 1'b1;
    tick();
    chk("t5_valid", 32'(valid_a), 32'd0);
    chk("t5_grant", 32'(grant), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_pulses", 32'({done, truncated, underrun}), 32'd0);
    rst = 1'b0;
    idle_reqs();
    clear_mon();
    start(2, 2, 0, -1);
    start(3, 2, 0, -1);
    ticks(40);
    if (q_owners.size() > 0) chk("t5_own0", 32'(q_owners[0]), 32'd2);

    // Request arriving mid-gap
    do_reset();
    start(0, 2, 0, -1);
    found = 0;
    for (int n = 0; n < 40; n++) begin
      if (!found) begin
        if (m_gap == GAP - 3) found = 1;
        else tick();
      end
    end
    chk("t6_reach", 32'(found), 32'd1);
    start(2, 3, 0, -1);
    ticks(40);
    chk("t6_nown", 32'(q_owners.size()), 32'd2);
    if (q_owners.size() == 2) chk("t6_own1", 32'(q_owners[1]), 32'd2);
    if (q_rise_gaps.size() > 0) chk("t6_spacing", 32'(q_rise_gaps[0]), 32'(GAP + 2));

    // Random traffic with occasional stalls and resets
    do_reset();
    rnd_mode = 1;
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (act[i] == 0 && $urandom_range(0, 99) < 10)
          start(i, int'($urandom_range(1, 24)), int'($urandom_range(0, 1)), -1);
      rst = ($urandom_range(0, 999) < 2);
      tick();
      if (rst) idle_reqs();
    end
    rst = 1'b0;
    rnd_mode = 0;
    idle_reqs();
    ticks(20);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
